gen_sample_scheduler: RTL and testbench

Sequences the signal generators (clean sine, dirty sine, noise, test ROMs) that feed the adaptive filter chain.
- Produces the common sample-rate tick and a phase-sync pulse for all generators.
- Selects one of four 24-bit generator outputs and captures it each sample period.
- Delivers the captured sample to the filter through a valid/ready handshake, counting samples dropped on overrun.

---
 rtl/gen_pkg.sv | 30 +++
 rtl/gen_rate_divider.sv | 33 +++
 rtl/gen_sample_scheduler.sv | 120 ++++++++++++
 tb/tb_gen_sample_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_pkg.sv
// Shared types and constants for the signal-generator sequencing blocks.
package gen_pkg;

  localparam int unsigned DW              = 24;
  localparam int unsigned N_SRC           = 4;
  localparam int unsigned SEL_W           = 2;
  localparam int unsigned IDX_W           = 16;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned CLK_DIV_DEFAULT = 50000;

  // Source indices, shared with the generator top level
  localparam logic [SEL_W-1:0] SRC_CLEAN = 2'd0;
  localparam logic [SEL_W-1:0] SRC_DIRTY = 2'd1;
  localparam logic [SEL_W-1:0] SRC_NOISE = 2'd2;
  localparam logic [SEL_W-1:0] SRC_AUX   = 2'd3;

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == '1) ? v : v + IDX_W'(1);
  endfunction

endpackage

// File: rtl/gen_rate_divider.sv
// Free-running clock divider with terminal-count pulse; held at zero when idle.
module gen_rate_divider
  import gen_pkg::*;
#(
  parameter int unsigned DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc_c
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_div_cnt;

  // Count 0..DIV-1 while enabled, otherwise hold at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == TC_VAL) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  assign o_tc_c = i_en && (r_div_cnt == TC_VAL);

endmodule

// File: rtl/gen_sample_scheduler.sv
// Sample-rate sequencer: sync/tick generation, source capture and output handshake.
module gen_sample_scheduler
  import gen_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [N_SRC*DW-1:0]   src_data,
  output logic                  gen_sync,
  output logic                  sample_tick,
  output sample_t               out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic [IDX_W-1:0]      overrun_cnt,
  output logic                  busy
);

  state_t           r_state;
  state_t           w_next_state;
  logic [SEL_W-1:0] r_active_sel;
  logic             r_cap;
  logic [IDX_W-1:0] r_run_idx;
  logic             w_sync;
  logic             w_run;
  logic             w_start;
  logic             w_tick;
  logic             w_slot_free;
  logic             w_accept;
  sample_t          w_sel_data;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state: SYNC always lasts one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (enable)  w_next_state = ST_SYNC;
      ST_SYNC:              w_next_state = ST_RUN;
      ST_RUN:  if (!enable) w_next_state = ST_IDLE;
      default:              w_next_state = ST_IDLE;
    endcase
  end

  assign w_sync  = (r_state == ST_SYNC);
  assign w_run   = (r_state == ST_RUN);
  assign w_start = (r_state == ST_IDLE) && enable;

  gen_rate_divider #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_run),
    .i_clr  (w_sync),
    .o_tc_c (w_tick)
  );

  assign gen_sync    = w_sync;
  assign sample_tick = w_tick;
  assign busy        = (r_state != ST_IDLE);

  assign w_sel_data  = src_data[r_active_sel*DW +: DW];
  assign w_accept    = out_valid && out_ready;
  assign w_slot_free = !out_valid || out_ready;

  // Source selection is latched only at sync and at each tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_active_sel <= SRC_CLEAN;
    else if (w_sync || w_tick) r_active_sel <= src_sel;
  end

  // Capture happens the cycle after a tick, once generator outputs have settled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cap <= 1'b0;
    else       r_cap <= w_tick;
  end

  // Output register, handshake, running index and overrun accounting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data    <= '0;
      out_idx     <= '0;
      out_valid   <= 1'b0;
      r_run_idx   <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (r_cap) begin
        if (w_slot_free) begin
          out_data  <= w_sel_data;
          out_idx   <= r_run_idx;
          out_valid <= 1'b1;
        end
      end else if (w_accept) begin
        out_valid <= 1'b0;
      end

      if (w_sync)     r_run_idx <= '0;
      else if (r_cap) r_run_idx <= r_run_idx + IDX_W'(1);

      if (w_start) begin
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end else if (r_cap && !w_slot_free) begin
        overrun     <= 1'b1;
        overrun_cnt <= sat_inc(overrun_cnt);
      end
    end
  end

endmodule

// File: tb/tb_gen_sample_scheduler.sv
// Self-checking bench for gen_sample_scheduler with a behavioural reference model.
module tb_gen_sample_scheduler;

  localparam int CLK_DIV = 8;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  src_sel;
  logic [95:0] src_data;
  logic        gen_sync;
  logic        sample_tick;
  logic signed [23:0] out_data;
  logic [15:0] out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic [15:0] overrun_cnt;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  gen_sample_scheduler #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .src_sel     (src_sel),
    .src_data    (src_data),
    .gen_sync    (gen_sync),
    .sample_tick (sample_tick),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 sync, 2 running
  int          m_mode;
  int          m_phase;
  bit          m_cap;
  int          m_sel;
  logic [23:0] m_data;
  int          m_idx;
  int          m_run;
  bit          m_valid;
  bit          m_ovr;
  int          m_ocnt;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_cap = 0; m_sel = 0; m_data = '0;
    m_idx = 0; m_run = 0; m_valid = 0; m_ovr = 0; m_ocnt = 0;
  endtask

  task automatic model_step();
    bit          tick;
    logic [95:0] d;
    logic [23:0] val;
    tick = (m_mode == 2) && (m_phase == CLK_DIV - 1);
    d    = src_data;
    val  = d[m_sel*24 +: 24];
    if (m_cap) begin
      if (!m_valid || out_ready) begin
        m_data = val; m_idx = m_run; m_valid = 1;
      end else begin
        m_ovr = 1;
        if (m_ocnt < 65535) m_ocnt++;
      end
      m_run = (m_run + 1) % 65536;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (m_mode == 0 && enable) begin m_ovr = 0; m_ocnt = 0; end
    if (m_mode == 1) m_run = 0;
    if (m_mode == 1 || tick) m_sel = int'(src_sel);
    m_cap   = tick;
    m_phase = (m_mode == 2 && enable) ? (m_phase + 1) % CLK_DIV : 0;
    case (m_mode)
      0:       m_mode = enable ? 1 : 0;
      1:       m_mode = 2;
      default: m_mode = enable ? 2 : 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("gen_sync",    32'(gen_sync),    32'(m_mode == 1));
    chk("sample_tick", 32'(sample_tick), 32'((m_mode == 2) && (m_phase == CLK_DIV - 1)));
    chk("busy",        32'(busy),        32'(m_mode != 0));
    chk("out_valid",   32'(out_valid),   32'(m_valid));
    chk("out_data",    {8'h0, out_data}, {8'h0, m_data});
    chk("out_idx",     {16'h0, out_idx}, 32'(m_idx));
    chk("overrun",     32'(overrun),     32'(m_ovr));
    chk("overrun_cnt", {16'h0, overrun_cnt}, 32'(m_ocnt));
  endtask

  // One clock: update model from pre-edge inputs, then compare just after the edge
  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    check_outputs();
  endtask

  task automatic wait_valid(input string tag);
    int b = 0;
    cyc();
    while (!out_valid && b < 40) begin cyc(); b++; end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_tick(input string tag);
    int b = 0;
    cyc();
    while (!sample_tick && b < 40) begin cyc(); b++; end
    chk(tag, 32'(sample_tick), 32'd1);
  endtask

  task automatic set_src(input int k, input logic [23:0] v);
    src_data[k*24 +: 24] = v;
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; src_sel = 2'd0; src_data = '0; out_ready = 1'b0;
    model_reset();
    #12;
    check_outputs();
    chk("rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #4;

    // Basic run: gen_sync, tick spacing, latency, index sequence
    enable = 1'b1; src_sel = 2'd1; set_src(1, 24'h1E81A3); out_ready = 1'b1;
    cyc();
    chk("sync_pulse", 32'(gen_sync), 32'd1);
    n = 0;
    do begin cyc(); n++; end while (!sample_tick && n < 40);
    chk("tick_gap", 32'(n), 32'd8);
    cyc();
    chk("lat_t1", 32'(out_valid), 32'd0);
    cyc();
    chk("lat_t2", 32'(out_valid), 32'd1);
    chk("basic_data", {8'h0, out_data}, 32'h001E81A3);
    chk("basic_idx0", {16'h0, out_idx}, 32'd0);
    wait_valid("to_idx1");
    chk("basic_idx1", {16'h0, out_idx}, 32'd1);
    wait_valid("to_idx2");
    chk("basic_idx2", {16'h0, out_idx}, 32'd2);

    // Overrun: stall for three sample periods
    enable = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b0; enable = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (overrun_cnt != 16'd2 && n < 60);
    chk("ovr_cnt2", {16'h0, overrun_cnt}, 32'd2);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_hold_idx", {16'h0, out_idx}, 32'd0);
    out_ready = 1'b1;
    cyc();
    chk("ovr_accept", 32'(out_valid), 32'd0);
    wait_valid("to_idx3");
    chk("ovr_next_idx", {16'h0, out_idx}, 32'd3);

    // Source switch: a change during the capture cycle only takes effect at the next tick
    enable = 1'b0;
    repeat (3) cyc();
    src_sel = 2'd0; set_src(0, 24'h000001); set_src(2, 24'hE17E5D); enable = 1'b1;
    wait_tick("to_tick_sw");
    cyc();
    src_sel = 2'd2;
    cyc();
    chk("sw_old_valid", 32'(out_valid), 32'd1);
    chk("sw_old_data", {8'h0, out_data}, 32'h00000001);
    wait_valid("to_sw_new");
    chk("sw_new_data", {8'h0, out_data}, 32'h00E17E5D);

    // Accept collides with capture: no overrun, new sample loaded
    out_ready = 1'b0;
    wait_tick("to_tick_col");
    cyc();
    out_ready = 1'b1;
    cyc();
    chk("col_valid", 32'(out_valid), 32'd1);
    chk("col_idx", {16'h0, out_idx}, 32'd2);
    chk("col_ovr_cnt", {16'h0, overrun_cnt}, 32'd0);

    // Disable with pending output, then re-enable
    out_ready = 1'b0;
    wait_tick("to_tick_dis");
    cyc();
    cyc();
    chk("dis_ovr_cnt", {16'h0, overrun_cnt}, 32'd1);
    enable = 1'b0;
    cyc();
    chk("dis_busy", 32'(busy), 32'd0);
    n = 0;
    repeat (20) begin cyc(); if (sample_tick) n++; end
    chk("dis_no_tick", 32'(n), 32'd0);
    chk("dis_hold_valid", 32'(out_valid), 32'd1);
    chk("dis_hold_idx", {16'h0, out_idx}, 32'd2);
    out_ready = 1'b1;
    cyc();
    chk("dis_accept", 32'(out_valid), 32'd0);
    enable = 1'b1;
    cyc();
    chk("re_sync", 32'(gen_sync), 32'd1);
    chk("re_ovr_cnt", {16'h0, overrun_cnt}, 32'd0);
    chk("re_ovr", 32'(overrun), 32'd0);
    wait_valid("to_re_valid");
    chk("re_idx0", {16'h0, out_idx}, 32'd0);

    // Asynchronous reset between clock edges
    out_ready = 1'b0;
    wait_valid("to_ar_valid");
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    check_outputs();
    #3 reset = 1'b0;
    repeat (3) cyc();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 24) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      src_sel   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) set_src($urandom_range(0, 3), 24'($urandom));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
